// File: rtl/request_encoder_if.sv
// -----------------------------------------------------------------------------
// request_encoder_if
//
// Groups the request and grant signals that pass between the request sources
// and the dispatch consumer on one side, and request_encoder on the other.
//
//   req     [N_REQ-1:0]  request strobes. Each set bit is latched as pending.
//   mask    [N_REQ-1:0]  1 = exclude this bit from selection. The bit stays pending.
//   ack                  consumer accepts the presented code.
//   valid                code is valid and stable.
//   code    [IDX_W-1:0]  binary index of the selected request.
//   pending [N_REQ-1:0]  current pending register, for observability.
//
// Modports:
//   master  the source/consumer side. It drives req, mask and ack.
//   slave   the encoder side. It drives valid, code and pending.
// -----------------------------------------------------------------------------
interface request_encoder_if #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] mask;
    logic             ack;
    logic             valid;
    logic [IDX_W-1:0] code;
    logic [N_REQ-1:0] pending;

    modport master (
        output req, mask, ack,
        input  valid, code, pending
    );

    modport slave (
        input  req, mask, ack,
        output valid, code, pending
    );
endinterface

// File: rtl/request_encoder.sv
// -----------------------------------------------------------------------------
// request_encoder
//
// Registered priority encoder with a valid/ack handshake.
//
// Request lines are latched into a pending register. In IDLE the encoder picks
// the lowest-index pending bit that is not masked, registers its index into
// code, and raises valid. It then holds that grant until ack arrives. On ack
// the serviced bit is cleared, unless the same bit is requested again in that
// cycle; in that case the new request wins and the bit stays pending.
//
// Ports:
//   clk    single clock. All state updates on the rising edge.
//   rst_n  asynchronous, active-low reset.
//   bus    request_encoder_if.slave. Carries req, mask and ack in, and
//          valid, code and pending out.
//
// valid and code come only from registers. There is no combinational path
// from req, mask or ack to either output.
// -----------------------------------------------------------------------------
module request_encoder #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    request_encoder_if.slave bus
);

    if (IDX_W != $clog2(N_REQ)) begin : g_width_check
        $error("request_encoder: IDX_W must equal clog2(N_REQ)");
    end

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] avail;
    logic [N_REQ-1:0] clr;
    logic [IDX_W-1:0] code;
    logic [IDX_W-1:0] sel;
    logic             found;
    logic             valid;

    // Selection uses the registered pending value only. A request that
    // arrives this cycle can therefore be granted no earlier than the
    // second edge after it arrives.
    assign avail = pending & ~bus.mask;

    // The loop scans from the highest index down, so the last match it finds
    // is the lowest index. The lowest index has the highest priority.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a
        // default value first. Without one, a path that leaves it unassigned
        // would infer a latch.
        sel   = '0;
        found = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (avail[i]) begin
                sel   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

    // An ack only clears a bit while a grant is being presented. An ack
    // that arrives while valid is low has no effect.
    always_comb begin
        clr = '0;
        if (valid && bus.ack) begin
            clr[code] = 1'b1;
        end
    end

    // OR-ing req in last lets a new request win over a clear of the same bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            // NOTE: sequential state is always written with non-blocking
            // assignments. Every register then samples values from before
            // the edge, whatever order the blocks run in.
            pending <= (pending & ~clr) | bus.req;
        end
    end

    // FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next-state logic. A grant that is being presented ignores new
    // higher-priority requests and mask changes. Only ack ends it.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (found)   state_nxt = PRESENT;
            PRESENT: if (bus.ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: output logic. valid is decoded from the state register alone.
    always_comb begin
        valid = (state == PRESENT);
    end

    // code is loaded only when a new grant starts. It is therefore frozen
    // while valid is high, and it keeps its last value while valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code <= '0;
        end else if (state == IDLE && found) begin
            code <= sel;
        end
    end

    assign bus.valid   = valid;
    assign bus.code    = code;
    assign bus.pending = pending;

endmodule
